// File: rtl/execute_stage.sv
// Y86-64 execute stage: D->E pipeline register, ALU, ZF/SF/OF condition codes, branch/cmov condition.
// Optional build macro EXEC_IADDQ_EN enables the IADDQ (icode 4'hC) instruction.
module execute_stage #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned STACK_INC = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              E_bubble_i,
  input  logic [2:0]        D_stat_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_ifun_i,
  input  logic [DATA_W-1:0] D_valC_i,
  input  logic [DATA_W-1:0] d_valA_i,
  input  logic [DATA_W-1:0] d_valB_i,
  input  logic [3:0]        d_dstE_i,
  input  logic [3:0]        d_dstM_i,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  input  logic [2:0]        m_stat_i,
  input  logic [2:0]        W_stat_i,
  output logic [2:0]        E_stat_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [3:0]        E_dstM_o,
  output logic [3:0]        E_srcA_o,
  output logic [3:0]        E_srcB_o,
  output logic [DATA_W-1:0] e_valE_o,
  output logic [3:0]        e_dstE_o,
  output logic              e_Cnd_o,
  output logic [2:0]        cc_o
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP    = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB,
    I_IADDQ  = 4'hC
  } icode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_XOR = 2'd3
  } alufun_e;

  localparam logic [2:0]        SAOK  = 3'd1;
  localparam logic [3:0]        NREG  = 4'hF;
  localparam logic [DATA_W-1:0] C_INC = DATA_W'(STACK_INC);
  localparam logic [DATA_W-1:0] C_DEC = '0 - C_INC;

  logic [2:0]        r_stat;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [DATA_W-1:0] r_valC;
  logic [DATA_W-1:0] r_valA;
  logic [DATA_W-1:0] r_valB;
  logic [3:0]        r_dstE;
  logic [3:0]        r_dstM;
  logic [3:0]        r_srcA;
  logic [3:0]        r_srcB;
  logic [2:0]        r_cc;

  logic [DATA_W-1:0] w_aluA;
  logic [DATA_W-1:0] w_aluB;
  logic [DATA_W-1:0] w_valE;
  logic              w_of;
  alufun_e           w_alufun;
  logic              w_cc_op;
  logic              w_set_cc;
  logic              w_cnd;
  logic              w_zf;
  logic              w_sf;
  logic              w_ofr;

  always_ff @(posedge clk_i) begin
    if (rst_i || E_bubble_i) begin
      r_stat  <= SAOK;
      r_icode <= I_NOP;
      r_ifun  <= '0;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= NREG;
      r_dstM  <= NREG;
      r_srcA  <= NREG;
      r_srcB  <= NREG;
    end else begin
      r_stat  <= D_stat_i;
      r_icode <= D_icode_i;
      r_ifun  <= D_ifun_i;
      r_valC  <= D_valC_i;
      r_valA  <= d_valA_i;
      r_valB  <= d_valB_i;
      r_dstE  <= d_dstE_i;
      r_dstM  <= d_dstM_i;
      r_srcA  <= d_srcA_i;
      r_srcB  <= d_srcB_i;
    end
  end

  always_comb begin
    w_aluA = '0;
    w_aluB = '0;
    case (r_icode)
      I_RRMOVQ:         w_aluA = r_valA;
      I_IRMOVQ:         w_aluA = r_valC;
      I_RMMOVQ,
      I_MRMOVQ: begin
        w_aluA = r_valC;
        w_aluB = r_valB;
      end
      I_OPQ: begin
        w_aluA = r_valA;
        w_aluB = r_valB;
      end
      I_CALL, I_PUSHQ: begin
        w_aluA = C_DEC;
        w_aluB = r_valB;
      end
      I_RET, I_POPQ: begin
        w_aluA = C_INC;
        w_aluB = r_valB;
      end
`ifdef EXEC_IADDQ_EN
      I_IADDQ: begin
        w_aluA = r_valC;
        w_aluB = r_valB;
      end
`endif
      default: begin
        w_aluA = '0;
        w_aluB = '0;
      end
    endcase
  end

  // OPQ with ifun above XOR is not a defined operation: result forced to zero, never sets CC.
  always_comb begin
    w_alufun = (r_icode == I_OPQ) ? alufun_e'(r_ifun[1:0]) : ALU_ADD;
    w_valE   = '0;
    w_of     = 1'b0;
    case (w_alufun)
      ALU_ADD: begin
        w_valE = w_aluB + w_aluA;
        w_of   = (w_aluA[DATA_W-1] == w_aluB[DATA_W-1]) && (w_valE[DATA_W-1] != w_aluA[DATA_W-1]);
      end
      ALU_SUB: begin
        w_valE = w_aluB - w_aluA;
        w_of   = (w_aluB[DATA_W-1] != w_aluA[DATA_W-1]) && (w_valE[DATA_W-1] != w_aluB[DATA_W-1]);
      end
      ALU_AND: w_valE = w_aluB & w_aluA;
      ALU_XOR: w_valE = w_aluB ^ w_aluA;
      default: w_valE = '0;
    endcase
    if ((r_icode == I_OPQ) && (r_ifun[3:2] != 2'b00)) begin
      w_valE = '0;
      w_of   = 1'b0;
    end
  end

`ifdef EXEC_IADDQ_EN
  assign w_cc_op = ((r_icode == I_OPQ) && (r_ifun[3:2] == 2'b00)) || (r_icode == I_IADDQ);
`else
  assign w_cc_op = (r_icode == I_OPQ) && (r_ifun[3:2] == 2'b00);
`endif

  assign w_set_cc = w_cc_op && (r_stat == SAOK) && (m_stat_i == SAOK) && (W_stat_i == SAOK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cc <= 3'b100;
    end else if (w_set_cc) begin
      r_cc <= {(w_valE == '0), w_valE[DATA_W-1], w_of};
    end
  end

  assign w_zf  = r_cc[2];
  assign w_sf  = r_cc[1];
  assign w_ofr = r_cc[0];

  always_comb begin
    w_cnd = 1'b0;
    case (r_ifun)
      4'd0:    w_cnd = 1'b1;
      4'd1:    w_cnd = (w_sf ^ w_ofr) | w_zf;
      4'd2:    w_cnd = w_sf ^ w_ofr;
      4'd3:    w_cnd = w_zf;
      4'd4:    w_cnd = ~w_zf;
      4'd5:    w_cnd = ~(w_sf ^ w_ofr);
      4'd6:    w_cnd = ~(w_sf ^ w_ofr) & ~w_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  assign E_stat_o  = r_stat;
  assign E_icode_o = r_icode;
  assign E_ifun_o  = r_ifun;
  assign E_valA_o  = r_valA;
  assign E_dstM_o  = r_dstM;
  assign E_srcA_o  = r_srcA;
  assign E_srcB_o  = r_srcB;
  assign e_valE_o  = w_valE;
  assign e_Cnd_o   = w_cnd;
  assign e_dstE_o  = ((r_icode == I_RRMOVQ) && !w_cnd) ? NREG : r_dstE;
  assign cc_o      = r_cc;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic against a reference model.
module tb_execute_stage;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } ereg_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        E_bubble_i = 1'b0;
  logic [2:0]  m_stat_i = 3'd1;
  logic [2:0]  W_stat_i = 3'd1;
  ereg_t       d_in;

  logic [2:0]  E_stat_o;
  logic [3:0]  E_icode_o, E_ifun_o, E_dstM_o, E_srcA_o, E_srcB_o, e_dstE_o;
  logic [63:0] E_valA_o, e_valE_o;
  logic        e_Cnd_o;
  logic [2:0]  cc_o;

  ereg_t       m_e;
  logic [2:0]  m_cc;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(64), .STACK_INC(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .E_bubble_i(E_bubble_i),
    .D_stat_i(d_in.stat), .D_icode_i(d_in.icode), .D_ifun_i(d_in.ifun), .D_valC_i(d_in.valC),
    .d_valA_i(d_in.valA), .d_valB_i(d_in.valB),
    .d_dstE_i(d_in.dstE), .d_dstM_i(d_in.dstM), .d_srcA_i(d_in.srcA), .d_srcB_i(d_in.srcB),
    .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
    .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o), .E_valA_o(E_valA_o),
    .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o),
    .e_valE_o(e_valE_o), .e_dstE_o(e_dstE_o), .e_Cnd_o(e_Cnd_o), .cc_o(cc_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ereg_t mk(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valC,
                               input logic [63:0] valA, input logic [63:0] valB, input logic [3:0] dstE);
    ereg_t e;
    e.stat = 3'd1; e.icode = icode; e.ifun = ifun; e.valC = valC; e.valA = valA; e.valB = valB;
    e.dstE = dstE; e.dstM = 4'hF; e.srcA = 4'hF; e.srcB = 4'hF;
    return e;
  endfunction

  function automatic ereg_t nop_e();
    return mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
  endfunction

  // Reference ALU: operands by instruction class, overflow from a 65-bit signed result.
  function automatic logic [63:0] m_alu(input ereg_t e, output logic of);
    logic [63:0] a, b;
    logic signed [64:0] w;
    int fn;
    a = 0; b = 0; fn = 0; of = 1'b0;
    case (e.icode)
      4'h2:       a = e.valA;
      4'h3:       a = e.valC;
      4'h4, 4'h5: begin a = e.valC; b = e.valB; end
      4'h6:       begin a = e.valA; b = e.valB; fn = int'(e.ifun); end
      4'h8, 4'hA: begin a = -64'sd8; b = e.valB; end
      4'h9, 4'hB: begin a = 64'd8; b = e.valB; end
`ifdef EXEC_IADDQ_EN
      4'hC:       begin a = e.valC; b = e.valB; end
`endif
      default: ;
    endcase
    case (fn)
      0: begin
        w = $signed({b[63], b}) + $signed({a[63], a});
        of = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (w < -65'sh0_8000_0000_0000_0000);
        return w[63:0];
      end
      1: begin
        w = $signed({b[63], b}) - $signed({a[63], a});
        of = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (w < -65'sh0_8000_0000_0000_0000);
        return w[63:0];
      end
      2: return a & b;
      3: return a ^ b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic m_cnd(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_setcc(input ereg_t e, input logic [2:0] ms, input logic [2:0] ws);
    logic op;
    op = (e.icode == 4'h6) && (e.ifun <= 4'd3);
`ifdef EXEC_IADDQ_EN
    op = op || (e.icode == 4'hC);
`endif
    return op && (e.stat == 3'd1) && (ms == 3'd1) && (ws == 3'd1);
  endfunction

  // Check every output against the model, then advance one edge in both DUT and model.
  task automatic cycle();
    logic of, c;
    logic [63:0] v;
    v = m_alu(m_e, of);
    c = m_cnd(m_e.ifun, m_cc);
    check_eq("E_stat", E_stat_o, m_e.stat);
    check_eq("E_icode", E_icode_o, m_e.icode);
    check_eq("E_ifun", E_ifun_o, m_e.ifun);
    check_eq("E_valA", E_valA_o, m_e.valA);
    check_eq("E_dstM", E_dstM_o, m_e.dstM);
    check_eq("E_srcA", E_srcA_o, m_e.srcA);
    check_eq("E_srcB", E_srcB_o, m_e.srcB);
    check_eq("e_valE", e_valE_o, v);
    check_eq("e_Cnd", e_Cnd_o, c);
    check_eq("e_dstE", e_dstE_o, (m_e.icode == 4'h2 && !c) ? 4'hF : m_e.dstE);
    check_eq("cc", cc_o, m_cc);
    @(posedge clk);
    if (rst_i) begin
      m_e = nop_e();
      m_cc = 3'b100;
    end else begin
      if (m_setcc(m_e, m_stat_i, W_stat_i)) m_cc = {v == 64'd0, v[63], of};
      m_e = E_bubble_i ? nop_e() : d_in;
    end
    #1;
  endtask

  function automatic logic [63:0] rval();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [2:0] rstat();
    return ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
  endfunction

  initial begin
    d_in = nop_e();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    m_e = nop_e();
    m_cc = 3'b100;

    check_eq("t1_icode", E_icode_o, 4'h1);
    check_eq("t1_dstE", e_dstE_o, 4'hF);
    check_eq("t1_dstM", E_dstM_o, 4'hF);
    check_eq("t1_valE", e_valE_o, 64'd0);
    check_eq("t1_cc", cc_o, 3'b100);

    d_in = mk(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2); cycle();
    check_eq("t2_valE", e_valE_o, 64'h8000_0000_0000_0000);
    d_in = nop_e(); cycle();
    check_eq("t2_cc", cc_o, 3'b011);

    d_in = mk(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2); cycle();
    check_eq("t3_valE", e_valE_o, 64'd0);
    d_in = mk(4'h7, 4'h4, 64'h100, 64'd0, 64'd0, 4'hF); cycle();
    check_eq("t3_cc", cc_o, 3'b100);
    check_eq("t3_jne", e_Cnd_o, 1'b0);
    d_in = mk(4'h7, 4'h3, 64'h100, 64'd0, 64'd0, 4'hF); cycle();
    check_eq("t3_je", e_Cnd_o, 1'b1);

    d_in = mk(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2); cycle();
    d_in = mk(4'h2, 4'h1, 64'd0, 64'd9, 64'd0, 4'h3); cycle();
    check_eq("t4_cc", cc_o, 3'b000);
    check_eq("t4_cnd", e_Cnd_o, 1'b0);
    check_eq("t4_dstE", e_dstE_o, 4'hF);
    check_eq("t4_valE", e_valE_o, 64'd9);

    d_in = mk(4'hA, 4'h0, 64'd0, 64'd7, 64'd64, 4'h4); cycle();
    check_eq("t5_valE", e_valE_o, 64'd56);
    check_eq("t5_dstE", e_dstE_o, 4'h4);
    E_bubble_i = 1'b1;
    d_in = mk(4'h6, 4'h0, 64'd0, 64'd3, 64'd3, 4'h2); cycle();
    E_bubble_i = 1'b0;
    check_eq("t5_bub_icode", E_icode_o, 4'h1);
    check_eq("t5_bub_dstE", e_dstE_o, 4'hF);
    check_eq("t5_bub_cc", cc_o, 3'b000);

    d_in = mk(4'h6, 4'h3, 64'd0, 64'd5, 64'd5, 4'h2); cycle();
    check_eq("t6_xor_valE", e_valE_o, 64'd0);
    m_stat_i = 3'd3;
    d_in = nop_e(); cycle();
    m_stat_i = 3'd1;
    check_eq("t6_xor_cc", cc_o, 3'b000);
    d_in = mk(4'hC, 4'h0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd3, 4'h5); cycle();
    check_eq("t6_iaddq_valE", e_valE_o, 64'd0);
    d_in = nop_e(); cycle();
`ifdef EXEC_IADDQ_EN
    check_eq("t6_iaddq_dstE_cc", cc_o, 3'b100);
`else
    check_eq("t6_iaddq_off_cc", cc_o, 3'b000);
`endif

    for (int n = 0; n < 600; n++) begin
      ereg_t r;
      rst_i = ($urandom_range(0, 63) == 0);
      E_bubble_i = ($urandom_range(0, 7) == 0);
      m_stat_i = rstat();
      W_stat_i = rstat();
      r.stat = rstat();
      r.icode = 4'($urandom_range(0, 15));
      r.ifun = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      r.valC = rval(); r.valA = rval(); r.valB = rval();
      r.dstE = 4'($urandom); r.dstM = 4'($urandom); r.srcA = 4'($urandom); r.srcB = 4'($urandom);
      d_in = r;
      cycle();
    end
    rst_i = 1'b0;
    E_bubble_i = 1'b0;
    m_stat_i = 3'd1;
    W_stat_i = 3'd1;
    d_in = nop_e();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
